// File: rtl/alu_ext.sv
// alu_ext: Hack-style ALU with shift ops and an optional shift-add multiplier.
// It accepts one operand/control bundle at a time through a valid/ready handshake.
// The result and flags stay registered until the consumer takes them.
module alu_ext #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             zr,
  output logic             ng,
  output logic             cy,
  output logic             ov
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  logic             accept;
  logic [WIDTH-1:0] xo;
  logic [WIDTH-1:0] yo;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             res_cy;
  logic             res_ov;

  logic             mul_last;
  logic [WIDTH-1:0] mul_res;
  logic             mul_ov;

  assign accept = in_valid && in_ready;

  // Operand preprocessing and the single-cycle result, taken straight from the inputs.
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    xo     = zx ? '0 : x;
    yo     = zy ? '0 : y;
    if (nx) xo = ~xo;
    if (ny) yo = ~yo;
    sum    = {1'b0, xo} + {1'b0, yo};
    res    = '0;
    res_cy = 1'b0;
    res_ov = 1'b0;
    unique case (op)
      2'b00: begin
        if (f) begin
          res    = sum[WIDTH-1:0];
          res_cy = sum[WIDTH];
          res_ov = (xo[WIDTH-1] == yo[WIDTH-1]) && (sum[WIDTH-1] != xo[WIDTH-1]);
        end else begin
          res = xo & yo;
        end
      end
      2'b01: begin
        res    = {xo[WIDTH-2:0], 1'b0};
        res_cy = xo[WIDTH-1];
        res_ov = xo[WIDTH-1] ^ xo[WIDTH-2];
      end
      2'b10: begin
        res    = {xo[WIDTH-1], xo[WIDTH-1:1]};
        res_cy = xo[0];
      end
      default: begin
        // Reached only when the multiplier is absent: a flagged zero result.
        res_ov = 1'b1;
      end
    endcase
    if (no) res = ~res;
  end

  generate
    if (MUL_EN) begin : g_mul
      logic [WIDTH-1:0]   mcand;
      logic [2*WIDTH-1:0] prod;
      logic [2*WIDTH-1:0] prod_next;
      logic [WIDTH:0]     psum;
      logic [CW-1:0]      cnt;
      logic               mul_no;

      // One partial product per cycle: add the multiplicand into the upper half, then shift right.
      always_comb begin
        psum      = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_next = {psum, prod[WIDTH-1:1]};
      end

      // Multiplier registers: load on acceptance of a multiply, step once per MUL cycle.
      always_ff @(posedge clk or posedge rst) begin
        // NOTE: the accumulator and counter are plain registers, so they are cleared by reset like any other state.
        if (rst) begin
          mcand  <= '0;
          prod   <= '0;
          cnt    <= '0;
          mul_no <= 1'b0;
        end else if (accept && (op == 2'b11)) begin
          mcand  <= xo;
          prod   <= {{WIDTH{1'b0}}, yo};
          cnt    <= CW'(WIDTH - 1);
          mul_no <= no;
        end else if (state == MUL) begin
          prod <= prod_next;
          cnt  <= cnt - 1'b1;
        end
      end

      assign mul_last = (cnt == '0);
      assign mul_res  = mul_no ? ~prod_next[WIDTH-1:0] : prod_next[WIDTH-1:0];
      assign mul_ov   = |prod_next[2*WIDTH-1:WIDTH];
    end else begin : g_no_mul
      assign mul_last = 1'b1;
      assign mul_res  = '0;
      assign mul_ov   = 1'b0;
    end
  endgenerate

  // Control FSM with registered handshake signals, result and flags.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      data_out  <= '0;
      zr        <= 1'b0;
      ng        <= 1'b0;
      cy        <= 1'b0;
      ov        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (MUL_EN && (op == 2'b11)) begin
              state <= MUL;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              data_out  <= res;
              zr        <= (res == '0);
              ng        <= res[WIDTH-1];
              cy        <= res_cy;
              ov        <= res_ov;
            end
          end
        end
        MUL: begin
          if (mul_last) begin
            state     <= DONE;
            out_valid <= 1'b1;
            data_out  <= mul_res;
            zr        <= (mul_res == '0);
            ng        <= mul_res[WIDTH-1];
            cy        <= 1'b0;
            ov        <= mul_ov;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
